// File: rtl/memory_pkg.sv
// Shared constants, region enum and address decode for the Hack data memory map.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
package memory_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;

    localparam logic [ADDR_W-1:0] RAM_BASE    = 15'h0000;
    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

    localparam int RAM_WORDS    = 16384;
    localparam int SCREEN_WORDS = 8192;

    typedef enum logic [1:0] {
        RAM,
        SCREEN,
        KBD,
        INVALID
    } region_t;

    // The screen window ends exactly where the keyboard word begins, so
    // KBD_ADDR doubles as the exclusive upper bound of the screen region.
    function automatic region_t decode_addr(input logic [ADDR_W-1:0] a);
        region_t r;
        if (a < SCREEN_BASE) begin
            r = RAM;
        end else if (a < KBD_ADDR) begin
            r = SCREEN;
        end else if (a == KBD_ADDR) begin
            r = KBD;
        end else begin
            r = INVALID;
        end
        return r;
    endfunction

endpackage

// File: rtl/memory_ram_bank.sv
// Word-addressed storage: one synchronous write port, two asynchronous read ports.
// Latency: write visible after the rising clk edge; reads are combinational.
// Backpressure: none; contents are never reset.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_a_i/rdata_a_o and
//        raddr_b_i/rdata_b_o (independent reads).
module ram_bank #(
    parameter int DEPTH  = 16384,
    parameter int DATA_W = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // No reset: storage holds whatever was last written (undefined at power-up).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/memory.sv
// Hack data memory map: 16K RAM, 8K screen buffer, keyboard word, invalid hole.
// Latency: writes land on the rising clk edge; out/scr_data are combinational.
// Backpressure: none; writes outside RAM/screen are dropped, reset blocks writes.
// Ports: in/load/address/out (CPU data port), key (keyboard scan code),
//        scr_addr/scr_data (display read port), clk, rst_n (async, active-low).
module memory #(
    parameter int DATA_W = memory_pkg::DATA_W,
    parameter int ADDR_W = memory_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    input  logic [DATA_W-1:0] key,
    input  logic [12:0]       scr_addr,
    output logic [DATA_W-1:0] scr_data
);
    import memory_pkg::*;

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);

    region_t           region;
    logic              ram_we;
    logic              scr_we;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] scr_rd_cpu;
    logic [DATA_W-1:0] scr_rd_disp;
    logic [DATA_W-1:0] ram_rdb_unused;

    assign region = decode_addr(address);

    // Reset gates the write enables rather than the storage, so contents survive.
    assign ram_we = load && rst_n && (region == RAM);
    assign scr_we = load && rst_n && (region == SCREEN);

    ram_bank #(
        .DEPTH  (RAM_WORDS),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .waddr_i   (address[RAM_AW-1:0]),
        .wdata_i   (in),
        .raddr_a_i (address[RAM_AW-1:0]),
        .rdata_a_o (ram_rd),
        .raddr_b_i (address[RAM_AW-1:0]),
        .rdata_b_o (ram_rdb_unused)
    );

    // Port A serves the CPU, port B the display controller.
    ram_bank #(
        .DEPTH  (SCREEN_WORDS),
        .DATA_W (DATA_W),
        .AW     (SCR_AW)
    ) u_screen (
        .clk       (clk),
        .we_i      (scr_we),
        .waddr_i   (address[SCR_AW-1:0]),
        .wdata_i   (in),
        .raddr_a_i (address[SCR_AW-1:0]),
        .rdata_a_o (scr_rd_cpu),
        .raddr_b_i (scr_addr),
        .rdata_b_o (scr_rd_disp)
    );

    always_comb begin
        out = '0;
        if (rst_n) begin
            case (region)
                RAM:     out = ram_rd;
                SCREEN:  out = scr_rd_cpu;
                KBD:     out = key;
                default: out = '0;
            endcase
        end
    end

    assign scr_data = rst_n ? scr_rd_disp : '0;

endmodule

// File: tb/tb_memory.sv
module tb_memory;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [14:0] address;
    logic [15:0] out;
    logic [15:0] key;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;

    int n_checks = 0;
    int n_fail   = 0;

    memory dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .load     (load),
        .address  (address),
        .out      (out),
        .key      (key),
        .scr_addr (scr_addr),
        .scr_data (scr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        in      = d;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load = 1'b0; in = 16'h0; address = 15'h0;
        key = 16'h1234; scr_addr = 13'h0;
        #2;
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_out: got %h want 0000", out);
        end
        rd(15'h6000);
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_out_kbd: got %h want 0000", out);
        end
        n_checks++;
        if (scr_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_scr: got %h want 0000", scr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram;
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) wr(15'(i), 16'(16'hA0 + i));
        for (int i = 0; i < 16; i++) begin
            exp = 16'(16'hA0 + i);
            rd(15'(i));
            n_checks++;
            if (out !== exp) begin
                n_fail++; $display("FAIL ram_rd[%0d]: got %h want %h", i, out, exp);
            end
        end
        wr(15'h3FFF, 16'h1234);
        rd(15'h3FFF);
        n_checks++;
        if (out !== 16'h1234) begin
            n_fail++; $display("FAIL ram_top: got %h want 1234", out);
        end
        rd(15'h0000);
        n_checks++;
        if (out !== 16'h00A0) begin
            n_fail++; $display("FAIL ram_zero: got %h want 00a0", out);
        end
    endtask

    task automatic test_screen;
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) wr(15'(15'h4000 + i), 16'(16'hB0 + i));
        for (int i = 0; i < 16; i++) begin
            exp = 16'(16'hB0 + i);
            scr_addr = 13'(i);
            rd(15'(15'h4000 + i));
            n_checks++;
            if (out !== exp) begin
                n_fail++; $display("FAIL scr_cpu[%0d]: got %h want %h", i, out, exp);
            end
            n_checks++;
            if (scr_data !== exp) begin
                n_fail++; $display("FAIL scr_disp[%0d]: got %h want %h", i, scr_data, exp);
            end
        end
        wr(15'h5FFF, 16'h5A5A);
        scr_addr = 13'h1FFF;
        #1;
        n_checks++;
        if (scr_data !== 16'h5A5A) begin
            n_fail++; $display("FAIL scr_top: got %h want 5a5a", scr_data);
        end
        // Display read of a word the CPU is writing in the same cycle.
        scr_addr = 13'h0002;
        @(negedge clk);
        address = 15'h4002; in = 16'hC0DE; load = 1'b1;
        #1;
        n_checks++;
        if (scr_data !== 16'h00B2) begin
            n_fail++; $display("FAIL scr_rdw_before: got %h want 00b2", scr_data);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        n_checks++;
        if (scr_data !== 16'hC0DE) begin
            n_fail++; $display("FAIL scr_rdw_after: got %h want c0de", scr_data);
        end
    endtask

    task automatic test_keyboard;
        wr(15'h2000, 16'h2222);
        key = 16'hFFFF;
        rd(15'h6000);
        n_checks++;
        if (out !== 16'hFFFF) begin
            n_fail++; $display("FAIL kbd_ffff: got %h want ffff", out);
        end
        key = 16'h0041;
        #1;
        n_checks++;
        if (out !== 16'h0041) begin
            n_fail++; $display("FAIL kbd_0041: got %h want 0041", out);
        end
        wr(15'h6000, 16'h9999);
        #1;
        n_checks++;
        if (out !== 16'h0041) begin
            n_fail++; $display("FAIL kbd_write: got %h want 0041", out);
        end
        // The keyboard write must not alias into RAM 0x2000 or screen index 0.
        rd(15'h2000);
        n_checks++;
        if (out !== 16'h2222) begin
            n_fail++; $display("FAIL kbd_alias_ram: got %h want 2222", out);
        end
        scr_addr = 13'h0000;
        #1;
        n_checks++;
        if (scr_data !== 16'h00B0) begin
            n_fail++; $display("FAIL kbd_alias_scr: got %h want 00b0", scr_data);
        end
    endtask

    task automatic test_invalid;
        wr(15'h3000, 16'h3333);
        wr(15'h5000, 16'h5555);
        key = 16'hABCD;
        rd(15'h6001);
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++; $display("FAIL inv_6001: got %h want 0000", out);
        end
        rd(15'h7000);
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++; $display("FAIL inv_7000: got %h want 0000", out);
        end
        wr(15'h7000, 16'hDEAD);
        #1;
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++; $display("FAIL inv_write: got %h want 0000", out);
        end
        rd(15'h3000);
        n_checks++;
        if (out !== 16'h3333) begin
            n_fail++; $display("FAIL inv_alias_ram: got %h want 3333", out);
        end
        scr_addr = 13'h1000;
        #1;
        n_checks++;
        if (scr_data !== 16'h5555) begin
            n_fail++; $display("FAIL inv_alias_scr: got %h want 5555", scr_data);
        end
    endtask

    task automatic test_load_gating;
        @(negedge clk);
        address = 15'h0005; in = 16'hFFFF; load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (out !== 16'h00A5) begin
            n_fail++; $display("FAIL load_gate: got %h want 00a5", out);
        end
        @(negedge clk);
        address = 15'h0007; in = 16'h0777; load = 1'b1;
        #1;
        n_checks++;
        if (out !== 16'h00A7) begin
            n_fail++; $display("FAIL rdw_before: got %h want 00a7", out);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        n_checks++;
        if (out !== 16'h0777) begin
            n_fail++; $display("FAIL rdw_after: got %h want 0777", out);
        end
    endtask

    task automatic test_reset_hold;
        scr_addr = 13'h0003;
        @(negedge clk);
        address = 15'h0003; in = 16'h7777; load = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++; $display("FAIL rst_hold_out: got %h want 0000", out);
        end
        n_checks++;
        if (scr_data !== 16'h0000) begin
            n_fail++; $display("FAIL rst_hold_scr: got %h want 0000", scr_data);
        end
        @(posedge clk);
        #1;
        load  = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (out !== 16'h00A3) begin
            n_fail++; $display("FAIL rst_release_out: got %h want 00a3", out);
        end
        n_checks++;
        if (scr_data !== 16'h00B3) begin
            n_fail++; $display("FAIL rst_release_scr: got %h want 00b3", scr_data);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_screen();
        test_keyboard();
        test_invalid();
        test_load_gating();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
